// File: rtl/adsr_envelope.sv
`default_nettype none
// ============================================================================
// Module      : adsr_envelope
// Description : Single-voice ADSR envelope stepped by a synchronised 100 Hz
//               tick, gated by a synchronised note trigger.
// Revision    : 1.0 - initial release
// ============================================================================
module adsr_envelope #(
    parameter int LEVEL_W = 12,
    parameter int RATE_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk100hz,
    input  logic               trigger,
    input  logic [RATE_W-1:0]  attack_rate,
    input  logic [RATE_W-1:0]  decay_rate,
    input  logic [LEVEL_W-1:0] sustain_level,
    input  logic [RATE_W-1:0]  release_rate,
    output logic [LEVEL_W-1:0] envelope,
    output logic [2:0]         state,
    output logic               active,
    output logic               note_done
);

    localparam logic [LEVEL_W-1:0] MAX_LEVEL = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             r_state;
    logic [LEVEL_W-1:0] r_env;
    logic               r_active;
    logic               r_note_done;
    logic [2:0]         r_tick_sync;
    logic [2:0]         r_gate_sync;

    // Bits [1:0] are the synchroniser, bit [2] the edge-detect history.
    logic w_tick, w_gate_rise, w_gate_fall;
    assign w_tick      =  r_tick_sync[1] & ~r_tick_sync[2];
    assign w_gate_rise =  r_gate_sync[1] & ~r_gate_sync[2];
    assign w_gate_fall = ~r_gate_sync[1] &  r_gate_sync[2];

    logic [LEVEL_W:0]   w_env_x, w_sus_x, w_att_x, w_dec_x, w_rel_x, w_att_sum;
    logic [LEVEL_W-1:0] w_dec_diff, w_rel_diff;
    logic               w_att_sat, w_dec_clamp, w_rel_zero;

    assign w_env_x    = {1'b0, r_env};
    assign w_sus_x    = {1'b0, sustain_level};
    assign w_att_x    = {{(LEVEL_W+1-RATE_W){1'b0}}, attack_rate};
    assign w_dec_x    = {{(LEVEL_W+1-RATE_W){1'b0}}, decay_rate};
    assign w_rel_x    = {{(LEVEL_W+1-RATE_W){1'b0}}, release_rate};
    assign w_att_sum  = w_env_x + w_att_x;
    assign w_att_sat  = (attack_rate == '0) || (w_att_sum >= {1'b0, MAX_LEVEL});
    // Covers both overshoot past sustain and a sustain raised above the level.
    assign w_dec_clamp = (decay_rate == '0) || (w_env_x <= (w_sus_x + w_dec_x));
    assign w_rel_zero  = (release_rate == '0) || (w_env_x <= w_rel_x);
    assign w_dec_diff = r_env - {{(LEVEL_W-RATE_W){1'b0}}, decay_rate};
    assign w_rel_diff = r_env - {{(LEVEL_W-RATE_W){1'b0}}, release_rate};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_env       <= '0;
            r_active    <= 1'b0;
            r_note_done <= 1'b0;
            r_tick_sync <= '0;
            r_gate_sync <= '0;
        end else begin
            r_tick_sync <= {r_tick_sync[1:0], clk100hz};
            r_gate_sync <= {r_gate_sync[1:0], trigger};
            r_note_done <= 1'b0;
            // Gate edges take priority; a coincident tick is dropped.
            if (w_gate_rise) begin
                r_state  <= S_ATTACK;
                r_active <= 1'b1;
            end else if (w_gate_fall && (r_state == S_ATTACK || r_state == S_DECAY ||
                                         r_state == S_SUSTAIN)) begin
                r_state  <= S_RELEASE;
                r_active <= 1'b1;
            end else if (w_tick) begin
                case (r_state)
                    S_IDLE: r_env <= '0;
                    S_ATTACK: begin
                        if (w_att_sat) begin
                            r_env   <= MAX_LEVEL;
                            r_state <= S_DECAY;
                        end else begin
                            r_env <= w_att_sum[LEVEL_W-1:0];
                        end
                    end
                    S_DECAY: begin
                        if (w_dec_clamp) begin
                            r_env   <= sustain_level;
                            r_state <= S_SUSTAIN;
                        end else begin
                            r_env <= w_dec_diff;
                        end
                    end
                    S_SUSTAIN: r_env <= sustain_level;
                    S_RELEASE: begin
                        if (w_rel_zero) begin
                            r_env       <= '0;
                            r_state     <= S_IDLE;
                            r_active    <= 1'b0;
                            r_note_done <= 1'b1;
                        end else begin
                            r_env <= w_rel_diff;
                        end
                    end
                    default: begin
                        r_env    <= '0;
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign envelope  = r_env;
    assign state     = r_state;
    assign active    = r_active;
    assign note_done = r_note_done;

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope.sv
`default_nettype none
// ============================================================================
// Module      : tb_adsr_envelope
// Description : Scoreboard bench for adsr_envelope; every observed output change
//               is matched against a queue of expected output states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adsr_envelope;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk100hz;
    logic        trigger;
    logic [7:0]  attack_rate, decay_rate, release_rate;
    logic [11:0] sustain_level;
    logic [11:0] envelope;
    logic [2:0]  state;
    logic        active, note_done;

    adsr_envelope #(.LEVEL_W(12), .RATE_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .clk100hz      (clk100hz),
        .trigger       (trigger),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .envelope      (envelope),
        .state         (state),
        .active        (active),
        .note_done     (note_done)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] env;
        logic        act;
        logic        nd;
    } obs_t;

    obs_t q_exp[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    obs_t cur_obs, prev_obs, exp_obs;

    task automatic push(input logic [2:0] st, input int env, input logic act, input logic nd);
        obs_t e;
        e.st = st; e.env = env[11:0]; e.act = act; e.nd = nd;
        q_exp.push_back(e);
    endtask

    task automatic check(input string name, input int act_v, input int req_v);
        checks++;
        if (act_v != req_v) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act_v, req_v);
        end
    endtask

    // Monitor: any change in the visible outputs is one DUT response.
    always @(negedge clk) begin
        cur_obs = '{st: state, env: envelope, act: active, nd: note_done};
        if (mon_en && cur_obs != prev_obs) begin
            checks++;
            if (q_exp.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change actual st=%0d env=%0d act=%0b nd=%0b required no change",
                         cur_obs.st, cur_obs.env, cur_obs.act, cur_obs.nd);
            end else begin
                exp_obs = q_exp.pop_front();
                if (cur_obs != exp_obs) begin
                    failures++;
                    $display("FAIL out_seq actual st=%0d env=%0d act=%0b nd=%0b required st=%0d env=%0d act=%0b nd=%0b",
                             cur_obs.st, cur_obs.env, cur_obs.act, cur_obs.nd,
                             exp_obs.st, exp_obs.env, exp_obs.act, exp_obs.nd);
                end
            end
        end
        prev_obs = cur_obs;
    end

    task automatic do_tick();
        @(negedge clk) clk100hz = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk) clk100hz = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic set_trigger(input logic v);
        @(negedge clk) trigger = v;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        reset = 1'b0; clk100hz = 1'b0; trigger = 1'b0;
        attack_rate = 8'd128; decay_rate = 8'd64; release_rate = 8'd255;
        sustain_level = 12'd2048;
        repeat (3) @(posedge clk);
        #1;
        check("reset_env",  envelope,  0);
        check("reset_state", state,    0);
        check("reset_active", active,  0);
        check("reset_note_done", note_done, 0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // IDLE ticks leave everything untouched
        do_tick();

        // Attack 128/tick, saturate on tick 32, then decay 64/tick to sustain 2048
        push(3'd1, 0, 1, 0);
        set_trigger(1'b1);
        for (int i = 1; i <= 31; i++) begin
            push(3'd1, 128 * i, 1, 0);
            do_tick();
        end
        push(3'd2, 4095, 1, 0);
        do_tick();
        for (int i = 1; i <= 31; i++) begin
            push(3'd2, 4095 - 64 * i, 1, 0);
            do_tick();
        end
        push(3'd3, 2048, 1, 0);
        do_tick();

        // Sustain tracks live level changes
        @(negedge clk) sustain_level = 12'd1000;
        push(3'd3, 1000, 1, 0);
        do_tick();
        @(negedge clk) sustain_level = 12'd2048;
        push(3'd3, 2048, 1, 0);
        do_tick();

        // Release 255/tick from 2048, note_done pulses exactly one clk
        push(3'd4, 2048, 1, 0);
        set_trigger(1'b0);
        for (int i = 1; i <= 8; i++) begin
            push(3'd4, 2048 - 255 * i, 1, 0);
            do_tick();
        end
        push(3'd0, 0, 0, 1);
        push(3'd0, 0, 0, 0);
        do_tick();

        // Zero rates: instant max, instant sustain
        @(negedge clk) begin attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 12'd1500; end
        push(3'd1, 0, 1, 0);
        set_trigger(1'b1);
        push(3'd2, 4095, 1, 0);
        do_tick();
        push(3'd3, 1500, 1, 0);
        do_tick();

        // Retrigger from RELEASE at 1500, attack continues from current level
        push(3'd4, 1500, 1, 0);
        set_trigger(1'b0);
        @(negedge clk) attack_rate = 8'd128;
        push(3'd1, 1500, 1, 0);
        set_trigger(1'b1);
        push(3'd1, 1628, 1, 0);
        do_tick();

        // release_rate 0: straight to IDLE on the first tick
        @(negedge clk) release_rate = 8'd0;
        push(3'd4, 1628, 1, 0);
        set_trigger(1'b0);
        push(3'd0, 0, 0, 1);
        push(3'd0, 0, 0, 0);
        do_tick();

        // Gate rise coincident with a tick: the tick is dropped
        push(3'd1, 0, 1, 0);
        set_trigger(1'b1);
        push(3'd1, 128, 1, 0);
        do_tick();
        @(negedge clk) release_rate = 8'd1;
        push(3'd4, 128, 1, 0);
        set_trigger(1'b0);
        push(3'd1, 128, 1, 0);
        @(negedge clk) begin trigger = 1'b1; clk100hz = 1'b1; end
        repeat (6) @(posedge clk);
        @(negedge clk) clk100hz = 1'b0;
        repeat (6) @(posedge clk);

        // Asynchronous reset mid-ATTACK with trigger held high
        push(3'd0, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        push(3'd1, 0, 1, 0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("post_reset_2clk_state", state, 0);
        @(posedge clk);
        #1 check("post_reset_3clk_state", state, 1);

        repeat (20) @(posedge clk);
        check("scoreboard_drained", q_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
